// File: rtl/instr_fetch_unit.sv
// Sequential RV32I fetch front end: PC, one-outstanding imem request, one-entry
// instruction buffer with valid/ready, redirect/kill handling. Optional FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [6:0]      opcode_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            fault_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_stall_o
`endif
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_KILL  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [XLEN-1:0] addr_r, addr_s;
  logic [XLEN-1:0] instr_r, instr_s;
  logic [XLEN-1:0] pc_r, pc_s;
  logic [XLEN-1:0] target_r, target_s;
  logic            valid_r, valid_s;
  logic            fault_r, fault_s;
  logic            req_s;
  logic            done_s;
  logic            misalign_s;

  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + {{(XLEN-3){1'b0}}, 3'b100};
  endfunction

  // Request is gated by rst_n so it stays low for the whole reset interval.
  assign req_s      = rst_n & ((state_r == ST_REQ) | (state_r == ST_KILL));
  assign done_s     = req_s & imem_rvalid_i;
  assign misalign_s = redirect_i & (redirect_pc_i[1:0] != 2'b00);

  // Next-state and next-register values for the fetch FSM.
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    instr_s  = instr_r;
    pc_s     = pc_r;
    target_s = target_r;
    valid_s  = valid_r;
    fault_s  = fault_r;
    case (state_r)
      ST_REQ: begin
        if (misalign_s) begin
          state_s = ST_FAULT;
          valid_s = 1'b0;
          fault_s = 1'b1;
        end else if (redirect_i) begin
          if (done_s) begin
            state_s = ST_REQ;
            addr_s  = redirect_pc_i;
          end else begin
            state_s  = ST_KILL;
            target_s = redirect_pc_i;
          end
        end else if (done_s) begin
          state_s = ST_HOLD;
          instr_s = imem_rdata_i;
          pc_s    = addr_r;
          valid_s = 1'b1;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (misalign_s) begin
          state_s = ST_FAULT;
          valid_s = 1'b0;
          fault_s = 1'b1;
        end else if (redirect_i) begin
          state_s = ST_REQ;
          addr_s  = redirect_pc_i;
          valid_s = 1'b0;
        end else if (instr_ready_i) begin
          state_s = ST_REQ;
          addr_s  = next_seq_pc(pc_r);
          valid_s = 1'b0;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_KILL: begin
        // The in-flight word is always dropped; the newest target wins.
        if (misalign_s) begin
          state_s = ST_FAULT;
          valid_s = 1'b0;
          fault_s = 1'b1;
        end else if (redirect_i) begin
          if (done_s) begin
            state_s = ST_REQ;
            addr_s  = redirect_pc_i;
          end else begin
            state_s  = ST_KILL;
            target_s = redirect_pc_i;
          end
        end else if (done_s) begin
          state_s = ST_REQ;
          addr_s  = target_r;
        end else begin
          state_s = ST_KILL;
        end
      end
      ST_FAULT: begin
        state_s = ST_FAULT;
        valid_s = 1'b0;
        fault_s = 1'b1;
      end
      default: begin
        state_s = ST_FAULT;
        valid_s = 1'b0;
        fault_s = 1'b1;
      end
    endcase
  end

  // State and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_REQ;
      addr_r   <= RESET_PC;
      instr_r  <= {XLEN{1'b0}};
      pc_r     <= RESET_PC;
      target_r <= {XLEN{1'b0}};
      valid_r  <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      addr_r   <= addr_s;
      instr_r  <= instr_s;
      pc_r     <= pc_s;
      target_r <= target_s;
      valid_r  <= valid_s;
      fault_r  <= fault_s;
    end
  end

  assign imem_req_o    = req_s;
  assign imem_addr_o   = addr_r;
  assign instr_valid_o = valid_r;
  assign instr_o       = instr_r;
  assign opcode_o      = instr_r[6:0];
  assign pc_o          = pc_r;
  assign fault_o       = fault_r;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_r;
  logic [31:0] stall_r;

  // Accepted-instruction and memory-stall event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_r <= 32'd0;
      stall_r   <= 32'd0;
    end else begin
      if (valid_r & instr_ready_i) begin
        fetched_r <= fetched_r + 32'd1;
      end else begin
        fetched_r <= fetched_r;
      end
      if (req_s & ~imem_rvalid_i) begin
        stall_r <= stall_r + 32'd1;
      end else begin
        stall_r <= stall_r;
      end
    end
  end

  assign perf_fetched_o = fetched_r;
  assign perf_stall_o   = stall_r;
`endif

endmodule
